// File: rtl/pcs_lock_pkg.sv
// Shared constants and state type for the PCS block-lock engine.
// Holds the sync header width, the clause 49 / clause 82 window defaults
// and the one-hot lock state encoding used by every lane.
package pcs_lock_pkg;

    localparam int HEAD_W        = 2;

    localparam int SH_CNT_N_49   = 64;
    localparam int SH_INV_MAX_49 = 16;
    localparam int SH_CNT_N_82   = 1024;
    localparam int SH_INV_MAX_82 = 65;

    typedef enum logic [3:0] {
        LOCK_INIT      = 4'b0001,
        LOCK_TEST      = 4'b0010,
        LOCK_SLIP_WAIT = 4'b0100,
        LOCK_LOCKED    = 4'b1000
    } lock_state_e;

    // A sync header is valid only as 01 or 10; 00 and 11 are illegal.
    function automatic logic sh_is_valid(input logic [HEAD_W-1:0] sh);
        return sh[1] ^ sh[0];
    endfunction

endpackage

// File: rtl/pcs_lane_lock_fsm.sv
// Single-lane block-lock state machine with its header and invalid-header
// counters and the gearbox slip handshake.
// Optional build macro PCS_LOCK_STATS_EN adds a saturating lock-loss counter
// with a clear input.
module pcs_lane_lock_fsm
    import pcs_lock_pkg::*;
#(
    parameter int SH_CNT_N   = SH_CNT_N_49,
    parameter int SH_INV_MAX = SH_INV_MAX_49
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_signal_ok,
    input  logic              i_head_v,
    input  logic [HEAD_W-1:0] i_head,
    input  logic              i_slip_done,
    output logic              o_slip,
    output logic              o_lock
`ifdef PCS_LOCK_STATS_EN
    ,
    input  logic              i_stats_clr,
    output logic [7:0]        o_lock_loss_cnt
`endif
);

    localparam int CNT_W = $clog2(SH_CNT_N + 1);
    localparam logic [CNT_W-1:0] SH_LAST  = CNT_W'(SH_CNT_N);
    localparam logic [CNT_W-1:0] INV_LAST = CNT_W'(SH_INV_MAX);

    lock_state_e      r_state;
    lock_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_sh_cnt;
    logic [CNT_W-1:0] w_sh_cnt_nxt;
    logic [CNT_W-1:0] r_inv_cnt;
    logic [CNT_W-1:0] w_inv_cnt_nxt;
    logic             r_slip;
    logic             w_slip_nxt;
    logic             w_head_bad;
    logic [CNT_W-1:0] w_sh_inc;
    logic [CNT_W-1:0] w_inv_inc;

    assign w_head_bad = ~sh_is_valid(i_head);
    assign w_sh_inc   = r_sh_cnt + CNT_W'(1);
    assign w_inv_inc  = (w_head_bad && (r_inv_cnt != INV_LAST)) ?
                        r_inv_cnt + CNT_W'(1) : r_inv_cnt;

    // Next-state and counter update; a lost signal overrides every other event.
    always_comb begin
        w_state_nxt   = r_state;
        w_sh_cnt_nxt  = r_sh_cnt;
        w_inv_cnt_nxt = r_inv_cnt;
        w_slip_nxt    = 1'b0;

        if (!i_signal_ok) begin
            w_state_nxt   = LOCK_INIT;
            w_sh_cnt_nxt  = '0;
            w_inv_cnt_nxt = '0;
        end else begin
            case (r_state)
                LOCK_INIT: begin
                    w_sh_cnt_nxt  = '0;
                    w_inv_cnt_nxt = '0;
                    w_state_nxt   = LOCK_TEST;
                end

                LOCK_TEST: begin
                    if (i_head_v) begin
                        if (w_head_bad) begin
                            w_state_nxt   = LOCK_SLIP_WAIT;
                            w_slip_nxt    = 1'b1;
                            w_sh_cnt_nxt  = '0;
                            w_inv_cnt_nxt = '0;
                        end else if (w_sh_inc == SH_LAST) begin
                            w_state_nxt   = LOCK_LOCKED;
                            w_sh_cnt_nxt  = '0;
                            w_inv_cnt_nxt = '0;
                        end else begin
                            w_sh_cnt_nxt  = w_sh_inc;
                        end
                    end
                end

                LOCK_SLIP_WAIT: begin
                    w_sh_cnt_nxt  = '0;
                    w_inv_cnt_nxt = '0;
                    if (i_slip_done) begin
                        w_state_nxt = LOCK_TEST;
                    end
                end

                LOCK_LOCKED: begin
                    if (i_head_v) begin
                        if (w_inv_inc == INV_LAST) begin
                            w_state_nxt   = LOCK_SLIP_WAIT;
                            w_slip_nxt    = 1'b1;
                            w_sh_cnt_nxt  = '0;
                            w_inv_cnt_nxt = '0;
                        end else if (w_sh_inc == SH_LAST) begin
                            w_sh_cnt_nxt  = '0;
                            w_inv_cnt_nxt = '0;
                        end else begin
                            w_sh_cnt_nxt  = w_sh_inc;
                            w_inv_cnt_nxt = w_inv_inc;
                        end
                    end
                end

                default: begin
                    w_state_nxt   = LOCK_INIT;
                    w_sh_cnt_nxt  = '0;
                    w_inv_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State, counters and the one-cycle slip request register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= LOCK_INIT;
            r_sh_cnt  <= '0;
            r_inv_cnt <= '0;
            r_slip    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sh_cnt  <= w_sh_cnt_nxt;
            r_inv_cnt <= w_inv_cnt_nxt;
            r_slip    <= w_slip_nxt;
        end
    end

    assign o_slip = r_slip;
    assign o_lock = (r_state == LOCK_LOCKED);

`ifdef PCS_LOCK_STATS_EN
    logic       w_lock_lost;
    logic [7:0] r_loss_cnt;

    assign w_lock_lost = (r_state == LOCK_LOCKED) && (w_state_nxt == LOCK_SLIP_WAIT);

    // Saturating count of lock losses; a clear in the same cycle as a loss wins.
    always_ff @(posedge clk) begin
        if (reset || i_stats_clr) begin
            r_loss_cnt <= '0;
        end else if (w_lock_lost && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
        end
    end

    assign o_lock_loss_cnt = r_loss_cnt;
`endif

endmodule

// File: rtl/pcs_lane_lock.sv
// Multi-lane PCS block-lock engine: one independent lock FSM per lane plus a
// registered all-lanes-locked status for the deskew stage.
// Optional build macro PCS_LOCK_STATS_EN adds per-lane lock-loss counters.
module pcs_lane_lock
    import pcs_lock_pkg::*;
#(
    parameter int LANE_N     = 4,
    parameter int HEAD_W     = pcs_lock_pkg::HEAD_W,
    parameter int SH_CNT_N   = SH_CNT_N_49,
    parameter int SH_INV_MAX = SH_INV_MAX_49
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANE_N-1:0]        signal_ok_i,
    input  logic [LANE_N-1:0]        head_v_i,
    input  logic [LANE_N*HEAD_W-1:0] head_i,
    output logic [LANE_N-1:0]        slip_o,
    input  logic [LANE_N-1:0]        slip_done_i,
    output logic [LANE_N-1:0]        lock_o,
    output logic                     all_lock_o
`ifdef PCS_LOCK_STATS_EN
    ,
    input  logic                     stats_clr_i,
    output logic [LANE_N*8-1:0]      lock_loss_cnt_o
`endif
);

    if (HEAD_W != 2) begin : g_bad_head_w
        $error("pcs_lane_lock: HEAD_W must be 2");
    end
    if ((LANE_N < 1) || (LANE_N > 20)) begin : g_bad_lane_n
        $error("pcs_lane_lock: LANE_N must be within 1..20");
    end
    if ((SH_INV_MAX < 1) || (SH_INV_MAX > SH_CNT_N)) begin : g_bad_inv_max
        $error("pcs_lane_lock: SH_INV_MAX must be within 1..SH_CNT_N");
    end

    logic [LANE_N-1:0] w_lock;
    logic              r_all_lock;

    for (genvar k = 0; k < LANE_N; k++) begin : g_lane
        pcs_lane_lock_fsm #(
            .SH_CNT_N   (SH_CNT_N),
            .SH_INV_MAX (SH_INV_MAX)
        ) u_fsm (
            .clk             (clk),
            .reset           (reset),
            .i_signal_ok     (signal_ok_i[k]),
            .i_head_v        (head_v_i[k]),
            .i_head          (head_i[k*HEAD_W +: HEAD_W]),
            .i_slip_done     (slip_done_i[k]),
            .o_slip          (slip_o[k]),
            .o_lock          (w_lock[k])
`ifdef PCS_LOCK_STATS_EN
            ,
            .i_stats_clr     (stats_clr_i),
            .o_lock_loss_cnt (lock_loss_cnt_o[k*8 +: 8])
`endif
        );
    end

    // Aggregate lock status, registered so it trails the lane locks by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_all_lock <= 1'b0;
        end else begin
            r_all_lock <= &w_lock;
        end
    end

    assign lock_o     = w_lock;
    assign all_lock_o = r_all_lock;

endmodule

// File: tb/tb_pcs_lane_lock.sv
// Self-checking bench for pcs_lane_lock: directed lock/slip/loss scenarios
// followed by randomized traffic, all compared against a behavioural model.
`timescale 1ns/1ps
module tb_pcs_lane_lock;

    localparam int LANE_N     = 4;
    localparam int SH_CNT_N   = 64;
    localparam int SH_INV_MAX = 16;

    localparam int M_IDLE   = 0;
    localparam int M_HUNT   = 1;
    localparam int M_WAIT   = 2;
    localparam int M_LOCKED = 3;

    localparam logic [1:0] GOOD = 2'b01;
    localparam logic [1:0] BAD  = 2'b11;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [LANE_N-1:0]     signal_ok_i;
    logic [LANE_N-1:0]     head_v_i;
    logic [LANE_N*2-1:0]   head_i;
    logic [LANE_N-1:0]     slip_done_i;
    logic [LANE_N-1:0]     slip_o;
    logic [LANE_N-1:0]     lock_o;
    logic                  all_lock_o;
    logic                  stClr;
`ifdef PCS_LOCK_STATS_EN
    logic [LANE_N*8-1:0]   lock_loss_cnt_o;
`endif

    int checkCount = 0;
    int errorCount = 0;

    // Behavioural model of each lane's lock status
    int                mMode [LANE_N];
    int                mGood [LANE_N];
    int                mBad  [LANE_N];
    int                mLoss [LANE_N];
    logic [LANE_N-1:0] mSlip;
    logic              mAll;

    // Stimulus for the next cycle
    logic                curRst;
    logic [LANE_N-1:0]   curOk;
    logic [LANE_N-1:0]   curHv;
    logic [LANE_N*2-1:0] curHd;
    logic [LANE_N-1:0]   curSd;
    logic                curClr;

    pcs_lane_lock #(
        .LANE_N     (LANE_N),
        .HEAD_W     (2),
        .SH_CNT_N   (SH_CNT_N),
        .SH_INV_MAX (SH_INV_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .signal_ok_i (signal_ok_i),
        .head_v_i    (head_v_i),
        .head_i      (head_i),
        .slip_o      (slip_o),
        .slip_done_i (slip_done_i),
        .lock_o      (lock_o),
        .all_lock_o  (all_lock_o)
`ifdef PCS_LOCK_STATS_EN
        ,
        .stats_clr_i     (stClr),
        .lock_loss_cnt_o (lock_loss_cnt_o)
`endif
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic applyStimulus(input logic rst, input logic [LANE_N-1:0] ok,
                                 input logic [LANE_N-1:0] hv, input logic [LANE_N*2-1:0] hd,
                                 input logic [LANE_N-1:0] sd, input logic clr);
        logic [LANE_N-1:0] lockNow;
        logic [LANE_N-1:0] expLock;
        logic [1:0]        h;
        logic              hGood;
        logic              lost;

        reset       = rst;
        signal_ok_i = ok;
        head_v_i    = hv;
        head_i      = hd;
        slip_done_i = sd;
        stClr       = clr;

        for (int k = 0; k < LANE_N; k++) lockNow[k] = (mMode[k] == M_LOCKED);
        mAll = rst ? 1'b0 : &lockNow;

        for (int k = 0; k < LANE_N; k++) begin
            h        = hd[k*2 +: 2];
            hGood    = (h == 2'b01) || (h == 2'b10);
            lost     = 1'b0;
            mSlip[k] = 1'b0;
            if (rst || !ok[k]) begin
                mMode[k] = M_IDLE;
                mGood[k] = 0;
                mBad[k]  = 0;
            end else if (mMode[k] == M_IDLE) begin
                mMode[k] = M_HUNT;
            end else if (mMode[k] == M_HUNT) begin
                if (hv[k] && !hGood) begin
                    mMode[k] = M_WAIT;
                    mSlip[k] = 1'b1;
                    mGood[k] = 0;
                end else if (hv[k]) begin
                    mGood[k]++;
                    if (mGood[k] == SH_CNT_N) begin
                        mMode[k] = M_LOCKED;
                        mGood[k] = 0;
                    end
                end
            end else if (mMode[k] == M_WAIT) begin
                if (sd[k]) mMode[k] = M_HUNT;
            end else if (hv[k]) begin
                mGood[k]++;
                if (!hGood) mBad[k]++;
                if (mBad[k] >= SH_INV_MAX) begin
                    mMode[k] = M_WAIT;
                    mSlip[k] = 1'b1;
                    lost     = 1'b1;
                    mGood[k] = 0;
                    mBad[k]  = 0;
                end else if (mGood[k] == SH_CNT_N) begin
                    mGood[k] = 0;
                    mBad[k]  = 0;
                end
            end
            if (rst || clr) mLoss[k] = 0;
            else if (lost && mLoss[k] < 255) mLoss[k]++;
            expLock[k] = (mMode[k] == M_LOCKED);
        end

        @(posedge clk);
        #1;
        checkOutput("lock_o", lock_o, expLock);
        checkOutput("slip_o", slip_o, mSlip);
        checkOutput("all_lock_o", all_lock_o, mAll);
`ifdef PCS_LOCK_STATS_EN
        for (int k = 0; k < LANE_N; k++)
            checkOutput("lock_loss_cnt_o", lock_loss_cnt_o[k*8 +: 8], mLoss[k]);
`endif
    endtask

    task automatic step();
        applyStimulus(curRst, curOk, curHv, curHd, curSd, curClr);
    endtask

    task automatic randomPhase(input int cycles, input int hvPct, input int badPct,
                               input int sdPct, input int dropPct, input int rstPermil);
        for (int c = 0; c < cycles; c++) begin
            curRst = ($urandom_range(999) < rstPermil);
            curClr = ($urandom_range(99) < 2);
            for (int k = 0; k < LANE_N; k++) begin
                curOk[k] = ($urandom_range(99) >= dropPct);
                curHv[k] = ($urandom_range(99) < hvPct);
                curSd[k] = ($urandom_range(99) < sdPct);
                if ($urandom_range(99) < badPct)
                    curHd[k*2 +: 2] = $urandom_range(1) ? 2'b11 : 2'b00;
                else
                    curHd[k*2 +: 2] = $urandom_range(1) ? 2'b10 : 2'b01;
            end
            step();
        end
    endtask

    // Guard against a hung run
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    // Main stimulus sequence
    initial begin
        for (int k = 0; k < LANE_N; k++) begin
            mMode[k] = M_IDLE; mGood[k] = 0; mBad[k] = 0; mLoss[k] = 0;
        end
        curRst = 1'b1; curOk = '0; curHv = '0; curHd = '0; curSd = '0; curClr = 1'b0;

        $display("[TB] reset");
        repeat (3) step();
        checkOutput("reset_outputs", {lock_o, slip_o, all_lock_o}, 0);
        curRst = 1'b0;

        $display("[TB] lane 0 locks after a full window");
        curOk[0] = 1'b1;
        step();
        curHv[0] = 1'b1; curHd[1:0] = GOOD;
        for (int i = 1; i <= SH_CNT_N; i++) begin
            step();
            if (i == SH_CNT_N - 1) checkOutput("lock_before_window", lock_o[0], 0);
            if (i == SH_CNT_N)     checkOutput("lock_after_window", lock_o[0], 1);
        end
        checkOutput("all_lock_partial", all_lock_o, 0);
        curHv[0] = 1'b0;

        $display("[TB] lane 1 slips on an invalid header");
        curOk[1] = 1'b1;
        step();
        curHv[1] = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            curHd[3:2] = (i == 10) ? BAD : GOOD;
            step();
        end
        checkOutput("slip_pulse", slip_o[1], 1);
        curHd[3:2] = GOOD;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("slip_single", slip_o[1], 0);
        end
        curSd[1] = 1'b1;
        step();
        curSd[1] = 1'b0;
        for (int i = 0; i < SH_CNT_N; i++) step();
        checkOutput("relock_after_slip", lock_o[1], 1);
        curHv[1] = 1'b0;

        $display("[TB] lane 0 invalid-header windows");
        curHv[0] = 1'b1;
        for (int w = 0; w < 4; w++) begin
            for (int j = 0; j < SH_CNT_N; j++) begin
                curHd[1:0] = (j >= ((w == 3) ? 48 : 49)) ? BAD : GOOD;
                step();
            end
            if (w == 2) checkOutput("lock_held_15_invalid", lock_o[0], 1);
        end
        checkOutput("lock_lost_16_invalid", {lock_o[0], slip_o[0]}, 2'b01);

        $display("[TB] signal loss during slip wait");
        curOk[0] = 1'b0; curSd[0] = 1'b1; curHv[0] = 1'b0;
        step();
        checkOutput("drop_in_slip_wait", {lock_o[0], slip_o[0]}, 0);
        curOk[0] = 1'b1; curSd[0] = 1'b0; curHv[0] = 1'b1; curHd[1:0] = BAD;
        step();
        checkOutput("init_ignores_header", slip_o[0], 0);
        step();
        checkOutput("slip_from_test", slip_o[0], 1);
        curHv[0] = 1'b0;

        $display("[TB] lane 2 with a 50%% header qualifier");
        curOk[2] = 1'b1;
        step();
        for (int i = 0; i < 130; i++) begin
            curHv[2]   = (i % 2 == 0);
            curHd[5:4] = curHv[2] ? GOOD : BAD;
            step();
            if (i == 124) checkOutput("half_rate_not_locked", lock_o[2], 0);
            if (i == 126) checkOutput("half_rate_locked", lock_o[2], 1);
        end

        $display("[TB] reset while locked");
        curRst = 1'b1;
        step();
        checkOutput("reset_mid_lock", {lock_o, slip_o, all_lock_o}, 0);
        curRst = 1'b0;

        $display("[TB] staggered lock on all lanes");
        curOk = '1; curHv = '0;
        for (int k = 0; k < LANE_N; k++) curHd[k*2 +: 2] = GOOD;
        step();
        for (int c = 0; c < 90; c++) begin
            for (int k = 0; k < LANE_N; k++) curHv[k] = (c >= 7 * k);
            step();
            if (c == 84) checkOutput("last_lane_lock", {lock_o, all_lock_o}, 5'b11110);
            if (c == 85) checkOutput("all_lock_rise", all_lock_o, 1);
        end
        curHd[3:2] = BAD;
        for (int j = 0; j < SH_INV_MAX; j++) step();
        checkOutput("loss_lane1", {lock_o[1], all_lock_o}, 2'b01);
        curHd[3:2] = GOOD;
        step();
        checkOutput("all_lock_fall", all_lock_o, 0);
`ifdef PCS_LOCK_STATS_EN
        checkOutput("loss_count_lane1", lock_loss_cnt_o[15:8], 1);
        curClr = 1'b1;
        step();
        curClr = 1'b0;
        checkOutput("loss_count_cleared", lock_loss_cnt_o, 0);
`endif

        $display("[TB] randomized traffic");
        randomPhase(500, 90, 0, 30, 0, 0);
        randomPhase(2000, 85, 20, 30, 0, 0);
        randomPhase(1000, 70, 8, 50, 1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
